// File: rtl/term_sm_pkg.sv
// Shared definitions for the loopback switch matrix: per-channel mode encoding
// and the number of configuration bits each channel occupies.
package term_sm_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_REG  = 2'b01,
    MODE_ZERO = 2'b10,
    MODE_ONE  = 2'b11
  } mode_e;

  localparam int BITS_PER_CH = 2;

endpackage

// File: rtl/term_sm_cfg_chain.sv
// Serial configuration chain: shift register, load counter and commit/abort logic.
// The active register only changes when a complete load is committed.
module term_sm_cfg_chain
  import term_sm_pkg::*;
#(
  parameter int CFGW = 72
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            conf_en_i,
  input  logic            conf_in_i,
  output logic            conf_out_o,
  output logic            conf_done_o,
  output logic [CFGW-1:0] active_o
);

  localparam int              CNTW = $clog2(CFGW + 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(CFGW);

  logic [CFGW-1:0] shift_q, shift_d;
  logic [CFGW-1:0] active_q, active_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            en_q, en_d;
  logic            done_q, done_d;

  always_comb begin
    shift_d  = shift_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    en_d     = conf_en_i;
    if (conf_en_i) begin
      shift_d = {shift_q[CFGW-2:0], conf_in_i};
      // A full counter seeing another shift means this bit starts a fresh load.
      cnt_d   = (cnt_q == FULL) ? CNTW'(1) : cnt_q + CNTW'(1);
      done_d  = 1'b0;
    end else if (en_q) begin
      if (cnt_q == FULL) begin
        active_d = shift_q;
        done_d   = 1'b1;
      end
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q  <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      done_q   <= done_d;
    end
  end

  assign conf_out_o  = shift_q[CFGW-1];
  assign conf_done_o = done_q;
  assign active_o    = active_q;

endmodule

// File: rtl/term_loopback_switch_matrix.sv
// Loopback switch matrix: index-reversed north->south wires with per-channel
// PASS/REG/ZERO/ONE modes. Define TERM_PIPE_REG_EN to build the REG-mode flops.
module term_loopback_switch_matrix
  import term_sm_pkg::*;
#(
  parameter int N1W = 4,
  parameter int N2W = 8,
  parameter int N4W = 16
) (
  input  logic           UserCLK,
  input  logic           Reset,
  input  logic           ConfEn,
  input  logic           ConfIn,
  output logic           ConfOut,
  output logic           ConfDone,
  input  logic [N1W-1:0] N1END,
  input  logic [N2W-1:0] N2MID,
  input  logic [N2W-1:0] N2END,
  input  logic [N4W-1:0] N4END,
  output logic [N1W-1:0] S1BEG,
  output logic [N2W-1:0] S2BEG,
  output logic [N2W-1:0] S2BEGb,
  output logic [N4W-1:0] S4BEG
);

  localparam int C    = N1W + 2*N2W + N4W;
  localparam int CFGW = BITS_PER_CH * C;

  logic [C-1:0]    src_w;
  logic [C-1:0]    out_w;
  logic [CFGW-1:0] active_w;

  term_sm_cfg_chain #(.CFGW(CFGW)) u_cfg (
    .clk_i       (UserCLK),
    .rst_i       (Reset),
    .conf_en_i   (ConfEn),
    .conf_in_i   (ConfIn),
    .conf_out_o  (ConfOut),
    .conf_done_o (ConfDone),
    .active_o    (active_w)
  );

  // Channel vector in output order; every source bus is wired index-reversed.
  always_comb begin
    src_w = '0;
    for (int i = 0; i < N1W; i++) src_w[i]                 = N1END[N1W-1-i];
    for (int i = 0; i < N2W; i++) src_w[N1W+i]             = N2MID[N2W-1-i];
    for (int i = 0; i < N2W; i++) src_w[N1W+N2W+i]         = N2END[N2W-1-i];
    for (int i = 0; i < N4W; i++) src_w[N1W+2*N2W+i]       = N4END[N4W-1-i];
  end

`ifdef TERM_PIPE_REG_EN
  logic [C-1:0] pipe_q;

  always_ff @(posedge UserCLK) begin
    if (Reset) pipe_q <= '0;
    else       pipe_q <= src_w;
  end
`endif

  always_comb begin
    out_w = src_w;
    for (int k = 0; k < C; k++) begin
      case (mode_e'(active_w[BITS_PER_CH*k +: BITS_PER_CH]))
        MODE_PASS: out_w[k] = src_w[k];
`ifdef TERM_PIPE_REG_EN
        MODE_REG:  out_w[k] = pipe_q[k];
`else
        MODE_REG:  out_w[k] = src_w[k];
`endif
        MODE_ZERO: out_w[k] = 1'b0;
        MODE_ONE:  out_w[k] = 1'b1;
        default:   out_w[k] = src_w[k];
      endcase
    end
  end

  assign S1BEG  = out_w[N1W-1:0];
  assign S2BEG  = out_w[N1W +: N2W];
  assign S2BEGb = out_w[N1W+N2W +: N2W];
  assign S4BEG  = out_w[N1W+2*N2W +: N4W];

endmodule
